// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller for the 8-bit common-bus CPU.
// Sequences datapath enables and owns the memory request/ack handshake with timeout.
module control_sequencer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic [7:0] ir,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic [1:0] bus_sel,
    output logic       pc_load_en,
    output logic       pc_sel,
    output logic       ir_load_en,
    output logic       mar_load_en,
    output logic       rf_write,
    output logic [1:0] rf_addr,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       bus_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPND   = 3'd3,
        S_EXEC   = 3'd4,
        S_MEMOP  = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LD  = 3'b010;
    localparam logic [2:0] OP_ST  = 3'b011;
    localparam logic [2:0] OP_ALU = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] wait_cnt_r;
    logic       bus_error_r;
    logic [2:0] opcode_s;
    logic       req_state_s;
    logic       timeout_s;

    assign opcode_s    = ir[7:5];
    assign req_state_s = (state_r == S_FETCH) || (state_r == S_OPND) || (state_r == S_MEMOP);
    // The last unacknowledged request cycle before giving up.
    assign timeout_s   = req_state_s && !mem_ack && (wait_cnt_r == WAIT_LAST);
    assign bus_error   = bus_error_r;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake wait counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r  <= 8'd0;
            bus_error_r <= 1'b0;
        end else begin
            if (!req_state_s || mem_ack || timeout_s) begin
                wait_cnt_r <= 8'd0;
            end else begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end
            if (timeout_s) begin
                bus_error_r <= 1'b1;
            end else begin
                bus_error_r <= bus_error_r;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_HALT: begin
                if (run) state_s = S_FETCH;
                else     state_s = state_r;
            end
            S_FETCH: begin
                if (mem_ack)        state_s = S_DECODE;
                else if (timeout_s) state_s = S_HALT;
                else                state_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_NOP:  state_s = S_FETCH;
                    OP_HLT:  state_s = S_HALT;
                    OP_ALU:  state_s = S_EXEC;
                    default: state_s = S_OPND;
                endcase
            end
            S_OPND: begin
                if (mem_ack) begin
                    case (opcode_s)
                        OP_LD, OP_ST: state_s = S_MEMOP;
                        OP_JMP:       state_s = S_EXEC;
                        OP_JZ:        state_s = alu_zero ? S_EXEC : S_FETCH;
                        default:      state_s = S_FETCH;
                    endcase
                end else if (timeout_s) begin
                    state_s = S_HALT;
                end else begin
                    state_s = S_OPND;
                end
            end
            S_MEMOP: begin
                if (mem_ack)        state_s = (opcode_s == OP_ST) ? S_FETCH : S_WB;
                else if (timeout_s) state_s = S_HALT;
                else                state_s = S_MEMOP;
            end
            S_WB:    state_s = S_FETCH;
            S_EXEC:  state_s = S_FETCH;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath control decode; enables qualified by state and mem_ack.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        bus_sel     = 2'd0;
        pc_load_en  = 1'b0;
        pc_sel      = 1'b0;
        ir_load_en  = 1'b0;
        mar_load_en = 1'b0;
        rf_write    = 1'b0;
        rf_addr     = 2'd0;
        alu_op      = 3'd0;
        halted      = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load_en = 1'b1;
                    pc_load_en = 1'b1;
                end else begin
                    ir_load_en = 1'b0;
                    pc_load_en = 1'b0;
                end
            end
            S_OPND: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_load_en = 1'b1;
                    case (opcode_s)
                        OP_LDI: begin
                            rf_write = 1'b1;
                            rf_addr  = ir[4:3];
                        end
                        OP_LD, OP_ST, OP_JMP: mar_load_en = 1'b1;
                        OP_JZ:   mar_load_en = alu_zero;
                        default: mar_load_en = 1'b0;
                    endcase
                end else begin
                    pc_load_en = 1'b0;
                end
            end
            S_MEMOP: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (opcode_s == OP_ST) begin
                    mem_we  = 1'b1;
                    bus_sel = 2'd1;
                    rf_addr = ir[4:3];
                end else begin
                    mem_we  = 1'b0;
                end
            end
            S_WB: begin
                rf_write = 1'b1;
                rf_addr  = ir[4:3];
            end
            S_EXEC: begin
                if (opcode_s == OP_ALU) begin
                    alu_op   = ir[2:0];
                    bus_sel  = 2'd2;
                    rf_write = 1'b1;
                    rf_addr  = ir[4:3];
                end else begin
                    pc_load_en = 1'b1;
                    pc_sel     = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

endmodule
